// File: rtl/wb_arbiter.sv
// wb_arbiter: four-requester write arbiter with a registered one-cycle grant path.
//
// Each rising edge, one requester is picked from req. A requester is not eligible
// if its gnt bit is high in the current cycle. Nobody is picked while stall is high.
// The winner's destination select and write data are registered onto out_sel and
// out_data. gnt and out_en pulse for one cycle. dst_en is the one-hot decode of
// out_sel, gated by out_en.
//
// Configuration macro: WB_ARB_RR_EN
//   defined   -> round-robin arbitration with a 2-bit pointer
//   undefined -> fixed priority, requester 0 highest
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req[3:0]  per-requester write request
//   dst[11:0] 3-bit destination select per requester
//   wdata     DW-bit write data per requester
//   stall     suppresses new grants
//   gnt       registered one-hot grant pulse
//   out_en    registered, high in the cycle a grant is issued
//   out_sel   registered destination select of the winner (held when idle)
//   out_data  registered write data of the winner (held when idle)
//   dst_en    registered one-hot decode of out_sel, gated by out_en
module wb_arbiter #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [11:0]     dst,
  input  logic [4*DW-1:0] wdata,
  input  logic            stall,
  output logic [3:0]      gnt,
  output logic            out_en,
  output logic [2:0]      out_sel,
  output logic [DW-1:0]   out_data,
  output logic [7:0]      dst_en
);

  logic [3:0]    gnt_q;
  logic          out_en_q;
  logic [2:0]    out_sel_q;
  logic [DW-1:0] out_data_q;
  logic [7:0]    dst_en_q;

  logic [3:0] elig;
  logic       found;
  logic [1:0] win;
  logic       grant;
  logic [2:0] win_sel;

  // The current grant doubles as the mask, so a requester cannot win twice in a row.
  assign elig = req & ~gnt_q;

`ifdef WB_ARB_RR_EN
  logic [1:0] ptr_q;

  // Search order starts at the pointer and wraps through the other requesters.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // The pointer moves only on a real grant, so stall leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (grant) begin
      ptr_q <= win + 2'd1;
    end
  end
`else
  // Fixed priority: the lowest index wins.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[k]) begin
        found = 1'b1;
        win   = 2'(k);
      end
    end
  end
`endif

  assign grant   = found && !stall;
  assign win_sel = dst[3*int'(win) +: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 4'd0;
      out_en_q   <= 1'b0;
      out_sel_q  <= 3'd0;
      out_data_q <= '0;
      dst_en_q   <= 8'd0;
    end else if (grant) begin
      gnt_q      <= 4'd1 << win;
      out_en_q   <= 1'b1;
      out_sel_q  <= win_sel;
      out_data_q <= wdata[DW*int'(win) +: DW];
      dst_en_q   <= 8'd1 << win_sel;
    end else begin
      // out_sel and out_data hold their last values.
      gnt_q    <= 4'd0;
      out_en_q <= 1'b0;
      dst_en_q <= 8'd0;
    end
  end

  assign gnt      = gnt_q;
  assign out_en   = out_en_q;
  assign out_sel  = out_sel_q;
  assign out_data = out_data_q;
  assign dst_en   = dst_en_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [11:0]     dst;
  logic [4*DW-1:0] wdata;
  logic            stall;
  logic [3:0]      gnt;
  logic            out_en;
  logic [2:0]      out_sel;
  logic [DW-1:0]   out_data;
  logic [7:0]      dst_en;

  int checks = 0;
  int failures = 0;

  // Reference model state: index of the last winner and the round-robin start point.
  int            m_last;
  int            m_ptr;
  logic [3:0]    e_gnt;
  logic          e_en;
  logic [2:0]    e_sel;
  logic [DW-1:0] e_data;
  logic [7:0]    e_dsten;

  logic [DW+15:0] act;
  logic [DW+15:0] exp_v;

  wb_arbiter #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dst      (dst),
    .wdata    (wdata),
    .stall    (stall),
    .gnt      (gnt),
    .out_en   (out_en),
    .out_sel  (out_sel),
    .out_data (out_data),
    .dst_en   (dst_en)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the model from the inputs seen at that edge,
  // then settle 1 time unit past the edge.
  task automatic tick();
    int w;
    int i;
    @(posedge clk);
    w = -1;
    if (rst) begin
      m_last = -1; m_ptr = 0;
      e_gnt = 0; e_en = 0; e_sel = 0; e_data = 0; e_dsten = 0;
    end else begin
      if (!stall) begin
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr + k) % 4;
          if (w < 0 && req[i] && i != m_last) w = i;
        end
      end
      if (w >= 0) begin
        e_gnt   = 4'd1 << w;
        e_en    = 1'b1;
        e_sel   = dst[3*w +: 3];
        e_data  = wdata[DW*w +: DW];
        e_dsten = 8'd1 << e_sel;
        m_last  = w;
`ifdef WB_ARB_RR_EN
        m_ptr   = (w + 1) % 4;
`endif
      end else begin
        e_gnt = 0; e_en = 0; e_dsten = 0;
        m_last = -1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'h0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; stall = 1'b0;
    dst = 12'hFFF; wdata = {4{32'hA5A5A5A5}};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      act = {gnt, out_en, out_sel, out_data, dst_en};
      if (act !== '0) begin
        failures++;
        $display("FAIL reset cycle %0d: got %h expected 0", c, act);
      end
    end
    rst = 1'b0; req = 4'h0;
    tick();
    checks++;
    act = {gnt, out_en, out_sel, out_data, dst_en};
    if (act !== '0) begin
      failures++;
      $display("FAIL reset_after: got %h expected 0", act);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; dst = 12'd0; dst[8:6] = 3'd5;
    wdata = '0; wdata[2*DW +: DW] = 32'hDEADBEEF;
    tick();
    checks++;
    if (gnt !== 4'b0100 || out_en !== 1'b1 || out_sel !== 3'd5 || dst_en !== 8'h20 ||
        out_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single: got gnt=%h en=%b sel=%0d dsten=%h data=%h expected 4 1 5 20 deadbeef",
               gnt, out_en, out_sel, dst_en, out_data);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0 || out_en !== 1'b0 || dst_en !== 8'h0 || out_sel !== 3'd5 ||
        out_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold: got gnt=%h en=%b dsten=%h sel=%0d data=%h expected 0 0 0 5 deadbeef",
               gnt, out_en, dst_en, out_sel, out_data);
    end
  endtask

  task automatic test_order();
    int order [5];
`ifdef WB_ARB_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 1, 0, 1, 0};
`endif
    do_reset();
    req = 4'hF; dst = 12'hFAC; wdata = {32'h4, 32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (gnt !== (4'd1 << order[c]) || out_data !== DW'(order[c] + 1)) begin
        failures++;
        $display("FAIL order step %0d: got gnt=%h data=%h expected gnt=%h", c, gnt, out_data,
                 4'd1 << order[c]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0010; dst = 12'h123; wdata = {4{32'h1111_2222}};
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0001; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_en !== 1'b0 || gnt !== 4'b0) begin
        failures++;
        $display("FAIL stall cycle %0d: got en=%b gnt=%h expected 0 0", c, out_en, gnt);
      end
    end
    stall = 1'b0; req = 4'b0101;
    tick();
    checks++;
    act = {gnt, out_en, out_sel, out_data, dst_en};
    exp_v = {e_gnt, e_en, e_sel, e_data, e_dsten};
    if (act !== exp_v || out_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got %h expected %h", act, exp_v);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    req = 4'b0010; dst = 12'h0; wdata = {4{32'hCAFE0000}};
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0 || dst_en !== 8'h0 || out_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset: got gnt=%h en=%b dsten=%h expected 0 0 0", gnt, out_en, dst_en);
    end
    rst = 1'b0; req = 4'hF;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_restart: got gnt=%h expected 1", gnt);
    end
  endtask

  task automatic test_decode();
    do_reset();
    wdata = '0;
    for (int s = 0; s < 8; s++) begin
      req = 4'b0001; dst = 12'(s);
      tick();
      checks++;
      if (dst_en !== (8'd1 << s) || out_sel !== 3'(s)) begin
        failures++;
        $display("FAIL decode %0d: got dsten=%h sel=%0d expected %h", s, dst_en, out_sel,
                 8'd1 << s);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (dst_en !== 8'h0) begin
        failures++;
        $display("FAIL decode_idle %0d: got dsten=%h expected 0", s, dst_en);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    req = 4'h0; dst = 12'h0; wdata = '0;
    for (int c = 0; c < 400; c++) begin
      // Requesters keep their transaction until granted, then drop or replace it.
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || e_gnt[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          dst[3*i +: 3] = 3'($urandom);
          wdata[DW*i +: DW] = $urandom;
        end
      end
      stall = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      act = {gnt, out_en, out_sel, out_data, dst_en};
      exp_v = {e_gnt, e_en, e_sel, e_data, e_dsten};
      if (act !== exp_v) begin
        failures++;
        $display("FAIL random cycle %0d: got %h expected %h", c, act, exp_v);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; dst = 12'h0; wdata = '0; stall = 1'b0;
    m_last = -1; m_ptr = 0;
    e_gnt = 0; e_en = 0; e_sel = 0; e_data = 0; e_dsten = 0;
    test_reset();
    test_single();
    test_order();
    test_stall();
    test_midreset();
    test_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DW, 32, width of write data per requester.
REQ-002 Port: clk  input  1  rising-edge clock; only clock in the block.
REQ-003 Port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 Port: req  input  4  per-requester write request, bit i = requester i.
REQ-005 Port: dst  input  12  destination select, bits [3i+2:3i] belong to requester i.
REQ-006 Port: wdata  input  4*DW  write data, bits [DW*i+DW-1:DW*i] belong to requester i.
REQ-007 Port: stall  input  1  when high, no new grant is issued.
REQ-008 Port: gnt  output  4  registered one-hot grant pulse.
REQ-009 Port: out_en  output  1  registered, high in the cycle a grant is issued.
REQ-010 Port: out_sel  output  3  registered destination select of the winner.
REQ-011 Port: out_data  output  DW  registered write data of the winner.
REQ-012 Port: dst_en  output  8  registered one-hot decode of out_sel, gated by out_en.

Function
REQ-013 Sampling: each rising edge not in reset, the block shall evaluate req, stall and the mask to pick at most one winner.
REQ-014 Mask: a requester whose gnt bit is high in the current cycle shall be ignored at the next edge.
REQ-015 Handshake: requester holds req/dst/wdata stable until it sees its gnt bit; it then drops req or presents a new transaction before the following edge.
REQ-016 Latency: one cycle; winner sampled at edge N -> gnt[w], out_en, out_sel = dst[w], out_data = wdata[w] and dst_en valid from edge N until edge N+1.
REQ-017 Pulse width: gnt and out_en shall be single-cycle pulses per transaction.
REQ-018 No grant: when no unmasked req is high or stall=1, next-cycle gnt=0, out_en=0 and dst_en=0.
REQ-019 Hold values: out_sel and out_data shall hold their last values when out_en=0.
REQ-020 Decode: dst_en[k]=1 iff out_en=1 and out_sel=k; otherwise dst_en=0.
REQ-021 Stall: stall sampled high suppresses only new grants; it does not alter the pointer or the held values.
REQ-022 Priority: with WB_ARB_RR_EN defined, arbitration shall be round-robin (REQ-027); otherwise requester 0 is highest priority and requester 3 lowest.
REQ-023 Throughput: one grant per cycle maximum; the same requester is granted at most every other cycle (REQ-014).

Reset
REQ-024 With rst high at a rising edge, the block shall force gnt=0, out_en=0, out_sel=0, out_data=0, dst_en=0, mask=0 and RR pointer=0.
REQ-025 Reset asserted mid-transaction shall drop any pending grant; no pulse shall be output in the cycle after the reset edge.
REQ-026 After rst is deasserted, the first grant shall appear no earlier than one cycle after the first non-reset sampling edge.

Configuration
REQ-027 With WB_ARB_RR_EN: 2-bit pointer p (reset 0); search order p, p+1, p+2, p+3 mod 4; after a grant to w, p = (w+1) mod 4; p unchanged when there is no grant.
REQ-028 Without WB_ARB_RR_EN: no pointer register; fixed priority 0>1>2>3; ports are unchanged.

Verification
REQ-029 Reset: rst=1 for 2 cycles with req=4'hF -> all outputs 0 throughout and 1 cycle after the reset edge.
REQ-030 Single request: req=4'b0100, dst[8:6]=5, wdata lane2=32'hDEADBEEF -> next cycle gnt=4'b0100, out_sel=5, dst_en=8'h20, out_data=32'hDEADBEEF, then gnt=0.
REQ-031 RR mode: req held at 4'hF and each winner re-asserts -> grant order 0,1,2,3,0; fixed mode: order 0,1,0,1 (mask alternation).
REQ-032 Stall: req=4'b0001 with stall=1 for 3 cycles -> out_en=0 during the stall; grant appears 1 cycle after stall drops; RR pointer unchanged.
REQ-033 Mid-reset: rst asserted in the same cycle gnt=4'b0010 is high -> next cycle gnt=0, dst_en=0, RR pointer=0.
REQ-034 Decode sweep: requester 0 issues dst=0..7 sequentially -> dst_en walks 8'h01..8'h80, exactly one bit per grant.
